// File: rtl/sysram_port_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// sysram_arb_pkg
// Shared definitions for the system-RAM port-B arbiter:
//   - source indices (pxw, uaw, c2h) and source count
//   - one-hot grant encoding, bit order {c2h,uaw,pxw}
//   - helpers for round-robin successor and one-hot conversion
// -----------------------------------------------------------------------------
package sysram_arb_pkg;

    localparam int unsigned NSRC = 3;

    typedef enum logic [1:0] {
        SRC_PXW = 2'd0,
        SRC_UAW = 2'd1,
        SRC_C2H = 2'd2
    } src_e;

    localparam logic [NSRC-1:0] GNT_NONE = 3'b000;
    localparam logic [NSRC-1:0] GNT_PXW  = 3'b001;
    localparam logic [NSRC-1:0] GNT_UAW  = 3'b010;
    localparam logic [NSRC-1:0] GNT_C2H  = 3'b100;

    // Round-robin successor: pxw -> uaw -> c2h -> pxw
    function automatic src_e next_src(input src_e s);
        case (s)
            SRC_PXW: return SRC_UAW;
            SRC_UAW: return SRC_C2H;
            default: return SRC_PXW;
        endcase
    endfunction

    function automatic logic [NSRC-1:0] src_onehot(input src_e s);
        case (s)
            SRC_PXW: return GNT_PXW;
            SRC_UAW: return GNT_UAW;
            SRC_C2H: return GNT_C2H;
            default: return GNT_NONE;
        endcase
    endfunction

endpackage

// File: rtl/sysram_port_arbiter_rr_arbiter3.sv
// -----------------------------------------------------------------------------
// rr_arbiter3
// Combinational 3-way round-robin pick.
//   i_elig  : eligible vector, bit order {c2h,uaw,pxw}
//   i_last  : last granted source; the search starts at its successor
//   o_grant : one-hot grant (zero when nothing is eligible)
//   o_idx   : index of the granted source (SRC_PXW when none)
//   o_any   : a grant was made
// -----------------------------------------------------------------------------
module rr_arbiter3
    import sysram_arb_pkg::*;
(
    input  logic [NSRC-1:0] i_elig,
    input  src_e            i_last,
    output logic [NSRC-1:0] o_grant,
    output src_e            o_idx,
    output logic            o_any
);

    src_e w_cand;

    always_comb begin
        o_grant = GNT_NONE;
        o_idx   = SRC_PXW;
        o_any   = 1'b0;
        w_cand  = next_src(i_last);
        for (int unsigned k = 0; k < NSRC; k++) begin
            if (!o_any && i_elig[w_cand]) begin
                o_any   = 1'b1;
                o_idx   = w_cand;
                o_grant = src_onehot(w_cand);
            end
            w_cand = next_src(w_cand);
        end
    end

endmodule

// File: rtl/sysram_port_arbiter.sv
// -----------------------------------------------------------------------------
// sysram_port_arbiter
// Shares CPU system-RAM port B between PXIe host writes (pxw), UART writes
// (uaw) and C2H readback reads (c2h) with round-robin arbitration. All RAM
// drive signals, grants and acks are registered; the port cycle follows the
// arbitration cycle by one clock.
//
// Ports:
//   I_clk, I_rst_n              clock, synchronous active-low reset
//   I_pxw_req/addr/data, O_pxw_ack    PXIe write requester
//   I_uaw_req/addr/data, O_uaw_ack    UART write requester
//   I_c2h_req/addr, O_c2h_ack         C2H read requester
//   O_c2h_rdata, O_c2h_rvld           read return (RD_LAT+1 after port cycle)
//   O_ram_en/wen/addr/wdata, I_ram_rdata   RAM port B
//   O_grant                     one-hot grant of current port cycle {c2h,uaw,pxw}
//   O_pxw_cnt/O_uaw_cnt/O_c2h_cnt      saturating accepted-access counters
// -----------------------------------------------------------------------------
module sysram_port_arbiter
    import sysram_arb_pkg::*;
#(
    parameter int unsigned AW     = 16,
    parameter int unsigned DW     = 32,
    parameter int unsigned RD_LAT = 1,
    parameter int unsigned CW     = 16
)(
    input  logic              I_clk,
    input  logic              I_rst_n,

    input  logic              I_pxw_req,
    input  logic [AW-1:0]     I_pxw_addr,
    input  logic [DW-1:0]     I_pxw_data,
    output logic              O_pxw_ack,

    input  logic              I_uaw_req,
    input  logic [AW-1:0]     I_uaw_addr,
    input  logic [DW-1:0]     I_uaw_data,
    output logic              O_uaw_ack,

    input  logic              I_c2h_req,
    input  logic [AW-1:0]     I_c2h_addr,
    output logic              O_c2h_ack,
    output logic [DW-1:0]     O_c2h_rdata,
    output logic              O_c2h_rvld,

    output logic              O_ram_en,
    output logic [DW/8-1:0]   O_ram_wen,
    output logic [AW-1:0]     O_ram_addr,
    output logic [DW-1:0]     O_ram_wdata,
    input  logic [DW-1:0]     I_ram_rdata,

    output logic [NSRC-1:0]   O_grant,
    output logic [CW-1:0]     O_pxw_cnt,
    output logic [CW-1:0]     O_uaw_cnt,
    output logic [CW-1:0]     O_c2h_cnt
);

    logic [NSRC-1:0] w_req;
    logic [NSRC-1:0] w_elig;
    logic [NSRC-1:0] w_gnt;
    src_e            w_idx;
    logic            w_any;

    // r_grant doubles as the per-source ack: the winner's ack is high for
    // exactly the port cycle it was granted.
    logic [NSRC-1:0] r_grant;
    // Last winner; reset to c2h so that pxw is first in line after reset.
    src_e            r_last;
    logic            r_ram_en;
    logic [DW/8-1:0] r_ram_wen;
    logic [AW-1:0]   r_ram_addr;
    logic [DW-1:0]   r_ram_wdata;
    logic [DW-1:0]   r_c2h_rdata;
    // Bit k is set in the (k+1)th cycle after a c2h port cycle.
    logic [RD_LAT:0] r_rvld_sr;
    logic [CW-1:0]   r_cnt [NSRC];

    assign w_req  = {I_c2h_req, I_uaw_req, I_pxw_req};
    // A source still holding req during its ack cycle is masked out.
    assign w_elig = w_req & ~r_grant;

    rr_arbiter3 u_rr (
        .i_elig  (w_elig),
        .i_last  (r_last),
        .o_grant (w_gnt),
        .o_idx   (w_idx),
        .o_any   (w_any)
    );

    always_ff @(posedge I_clk) begin
        if (!I_rst_n) begin
            r_grant     <= '0;
            r_last      <= SRC_C2H;
            r_ram_en    <= 1'b0;
            r_ram_wen   <= '0;
            r_ram_addr  <= '0;
            r_ram_wdata <= '0;
            r_c2h_rdata <= '0;
            r_rvld_sr   <= '0;
            for (int unsigned s = 0; s < NSRC; s++) begin
                r_cnt[s] <= '0;
            end
        end else begin
            r_grant   <= w_gnt;
            r_ram_en  <= w_any;
            r_ram_wen <= '0;
            if (w_any) begin
                r_last <= w_idx;
                case (w_idx)
                    SRC_PXW: begin
                        r_ram_addr  <= I_pxw_addr;
                        r_ram_wdata <= I_pxw_data;
                        r_ram_wen   <= '1;
                    end
                    SRC_UAW: begin
                        r_ram_addr  <= I_uaw_addr;
                        r_ram_wdata <= I_uaw_data;
                        r_ram_wen   <= '1;
                    end
                    default: begin
                        // Reads carry no data; wdata keeps its last value.
                        r_ram_addr <= I_c2h_addr;
                    end
                endcase
            end

            r_rvld_sr <= {r_rvld_sr[RD_LAT-1:0], r_grant[SRC_C2H]};
            if (r_rvld_sr[RD_LAT-1]) begin
                r_c2h_rdata <= I_ram_rdata;
            end

            for (int unsigned s = 0; s < NSRC; s++) begin
                if (r_grant[s] && (r_cnt[s] != '1)) begin
                    r_cnt[s] <= r_cnt[s] + 1'b1;
                end
            end
        end
    end

    assign O_pxw_ack   = r_grant[SRC_PXW];
    assign O_uaw_ack   = r_grant[SRC_UAW];
    assign O_c2h_ack   = r_grant[SRC_C2H];
    assign O_grant     = r_grant;
    assign O_ram_en    = r_ram_en;
    assign O_ram_wen   = r_ram_wen;
    assign O_ram_addr  = r_ram_addr;
    assign O_ram_wdata = r_ram_wdata;
    assign O_c2h_rdata = r_c2h_rdata;
    assign O_c2h_rvld  = r_rvld_sr[RD_LAT];
    assign O_pxw_cnt   = r_cnt[SRC_PXW];
    assign O_uaw_cnt   = r_cnt[SRC_UAW];
    assign O_c2h_cnt   = r_cnt[SRC_C2H];

endmodule

// File: tb/tb_sysram_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_sysram_port_arbiter
// Scoreboard bench: a reference model at each rising edge predicts the next
// port cycle (grant, RAM drive, acks, counters) and the read-return cycle and
// data, pushing them into queues; a monitor on the falling edge pops and
// compares. A second instance with 4-bit counters exercises saturation.
// -----------------------------------------------------------------------------
module tb_sysram_port_arbiter;

    localparam int RD_LAT = 1;

    typedef struct packed {
        logic [2:0]       gnt;
        logic             en;
        logic [3:0]       wen;
        logic [15:0]      addr;
        logic [31:0]      wdata;
        logic [2:0][15:0] cnt;
    } exp_t;

    typedef struct packed {
        logic [31:0] cyc;
        logic [31:0] d;
    } ret_t;

    typedef struct packed {
        logic [15:0] a;
        logic [31:0] d;
    } txn_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        pxw_req, uaw_req, c2h_req;
    logic [15:0] pxw_addr, uaw_addr, c2h_addr;
    logic [31:0] pxw_data, uaw_data;
    logic        pxw_ack, uaw_ack, c2h_ack, c2h_rvld, ram_en;
    logic [31:0] c2h_rdata, ram_wdata;
    logic [31:0] ram_rdata = '0;
    logic [3:0]  ram_wen;
    logic [15:0] ram_addr;
    logic [2:0]  grant;
    logic [15:0] pxw_cnt, uaw_cnt, c2h_cnt;

    logic        d2_pxw_ack, d2_uaw_ack, d2_c2h_ack, d2_c2h_rvld, d2_ram_en;
    logic [31:0] d2_c2h_rdata, d2_ram_wdata;
    logic [3:0]  d2_ram_wen;
    logic [15:0] d2_ram_addr;
    logic [2:0]  d2_grant;
    logic [3:0]  d2_pxw_cnt, d2_uaw_cnt, d2_c2h_cnt;

    sysram_port_arbiter #(.AW(16), .DW(32), .RD_LAT(RD_LAT), .CW(16)) u_dut (
        .I_clk(clk), .I_rst_n(rst_n),
        .I_pxw_req(pxw_req), .I_pxw_addr(pxw_addr), .I_pxw_data(pxw_data), .O_pxw_ack(pxw_ack),
        .I_uaw_req(uaw_req), .I_uaw_addr(uaw_addr), .I_uaw_data(uaw_data), .O_uaw_ack(uaw_ack),
        .I_c2h_req(c2h_req), .I_c2h_addr(c2h_addr), .O_c2h_ack(c2h_ack),
        .O_c2h_rdata(c2h_rdata), .O_c2h_rvld(c2h_rvld),
        .O_ram_en(ram_en), .O_ram_wen(ram_wen), .O_ram_addr(ram_addr),
        .O_ram_wdata(ram_wdata), .I_ram_rdata(ram_rdata),
        .O_grant(grant), .O_pxw_cnt(pxw_cnt), .O_uaw_cnt(uaw_cnt), .O_c2h_cnt(c2h_cnt)
    );

    sysram_port_arbiter #(.AW(16), .DW(32), .RD_LAT(RD_LAT), .CW(4)) u_dut_sat (
        .I_clk(clk), .I_rst_n(rst_n),
        .I_pxw_req(pxw_req), .I_pxw_addr(pxw_addr), .I_pxw_data(pxw_data), .O_pxw_ack(d2_pxw_ack),
        .I_uaw_req(uaw_req), .I_uaw_addr(uaw_addr), .I_uaw_data(uaw_data), .O_uaw_ack(d2_uaw_ack),
        .I_c2h_req(c2h_req), .I_c2h_addr(c2h_addr), .O_c2h_ack(d2_c2h_ack),
        .O_c2h_rdata(d2_c2h_rdata), .O_c2h_rvld(d2_c2h_rvld),
        .O_ram_en(d2_ram_en), .O_ram_wen(d2_ram_wen), .O_ram_addr(d2_ram_addr),
        .O_ram_wdata(d2_ram_wdata), .I_ram_rdata(ram_rdata),
        .O_grant(d2_grant), .O_pxw_cnt(d2_pxw_cnt), .O_uaw_cnt(d2_uaw_cnt), .O_c2h_cnt(d2_c2h_cnt)
    );

    int n_vec = 0;
    int n_bad = 0;
    logic [31:0] cyc_n = '0;

    exp_t exp_q[$];
    ret_t ret_q[$];
    txn_t q0[$], q1[$], q2[$];
    bit   gaps = 1'b0;

    function automatic logic [31:0] fill(input logic [15:0] a);
        return {16'hA5C3, ~a};
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc_n);
        end
    endtask

    // Environment RAM, one-cycle read latency.
    logic [31:0] mem [int unsigned];
    always @(posedge clk) begin
        if (ram_en) begin
            if (ram_wen != 4'h0) mem[ram_addr] = ram_wdata;
            else ram_rdata <= mem.exists(ram_addr) ? mem[ram_addr] : fill(ram_addr);
        end
    end

    // Reference model: predicts the port cycle that follows each rising edge.
    logic [31:0] ref_mem [int unsigned];
    initial begin
        int          m_last;
        logic [2:0]  m_ack;
        logic [15:0] m_cnt [3];
        logic [15:0] m_addr;
        logic [31:0] m_wdata;
        logic [2:0]  elig;
        exp_t        e;
        bit          found;
        int          pick;
        logic [31:0] rd;
        m_last = 2; m_ack = '0; m_addr = '0; m_wdata = '0;
        for (int i = 0; i < 3; i++) m_cnt[i] = '0;
        forever begin
            @(posedge clk);
            cyc_n = cyc_n + 1;
            e = '0;
            if (!rst_n) begin
                m_last = 2; m_ack = '0; m_addr = '0; m_wdata = '0;
                for (int i = 0; i < 3; i++) m_cnt[i] = '0;
                ret_q.delete();
            end else begin
                for (int i = 0; i < 3; i++)
                    if (m_ack[i] && m_cnt[i] != 16'hFFFF) m_cnt[i] = m_cnt[i] + 1;
                elig  = {c2h_req, uaw_req, pxw_req} & ~m_ack;
                found = 0;
                pick  = 0;
                for (int k = 1; k <= 3; k++) begin
                    if (!found && elig[(m_last + k) % 3]) begin
                        found = 1;
                        pick  = (m_last + k) % 3;
                    end
                end
                if (found) begin
                    m_last = pick;
                    e.en   = 1'b1;
                    e.gnt  = 3'b001 << pick;
                    if (pick == 0) begin
                        m_addr = pxw_addr; m_wdata = pxw_data; e.wen = 4'hF;
                        ref_mem[m_addr] = m_wdata;
                    end else if (pick == 1) begin
                        m_addr = uaw_addr; m_wdata = uaw_data; e.wen = 4'hF;
                        ref_mem[m_addr] = m_wdata;
                    end else begin
                        m_addr = c2h_addr;
                        rd = ref_mem.exists(m_addr) ? ref_mem[m_addr] : fill(m_addr);
                        ret_q.push_back({cyc_n + RD_LAT + 1, rd});
                    end
                end
                m_ack = e.gnt;
                e.addr  = m_addr;
                e.wdata = m_wdata;
                for (int i = 0; i < 3; i++) e.cnt[i] = m_cnt[i];
            end
            exp_q.push_back(e);
        end
    end

    // Monitor: compares every port cycle and read return against the model.
    initial begin
        exp_t e;
        bit   rv;
        int   w [3];
        logic [2:0] rq, ak;
        for (int i = 0; i < 3; i++) w[i] = 0;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("grant",   grant,    e.gnt);
                chk("ram_en",  ram_en,   e.en);
                chk("ram_wen", ram_wen,  e.wen);
                chk("ram_addr", ram_addr, e.addr);
                chk("ram_wdata", ram_wdata, e.wdata);
                chk("acks", {c2h_ack, uaw_ack, pxw_ack}, e.gnt);
                chk("pxw_cnt", pxw_cnt, e.cnt[0]);
                chk("uaw_cnt", uaw_cnt, e.cnt[1]);
                chk("c2h_cnt", c2h_cnt, e.cnt[2]);
                chk("sat_grant", d2_grant, e.gnt);
                chk("sat_pxw_cnt", d2_pxw_cnt, (e.cnt[0] > 15) ? 16'd15 : e.cnt[0]);
                chk("sat_uaw_cnt", d2_uaw_cnt, (e.cnt[1] > 15) ? 16'd15 : e.cnt[1]);
                chk("sat_c2h_cnt", d2_c2h_cnt, (e.cnt[2] > 15) ? 16'd15 : e.cnt[2]);
                rv = (ret_q.size() > 0) && (ret_q[0].cyc == cyc_n);
                chk("rvld", c2h_rvld, rv);
                if (rv) begin
                    chk("rdata", c2h_rdata, ret_q[0].d);
                    void'(ret_q.pop_front());
                end
            end
            // Wait-time bound for a held request.
            rq = {c2h_req, uaw_req, pxw_req};
            ak = {c2h_ack, uaw_ack, pxw_ack};
            for (int i = 0; i < 3; i++) begin
                if (!rst_n) w[i] = 0;
                else if (rq[i] && ak[i]) begin
                    chk("starve_bound", (w[i] <= 3), 1'b1);
                    w[i] = 0;
                end else if (rq[i]) w[i] = w[i] + 1;
            end
        end
    end

    // Requester driver: holds req/addr/data until ack, then takes the next txn.
    initial begin
        logic [2:0] a;
        logic       rn;
        txn_t       t;
        pxw_req = 0; uaw_req = 0; c2h_req = 0;
        pxw_addr = '0; uaw_addr = '0; c2h_addr = '0; pxw_data = '0; uaw_data = '0;
        forever begin
            @(negedge clk);
            a  = {c2h_ack, uaw_ack, pxw_ack};
            rn = rst_n;
            #1;
            if (pxw_req && a[0]) pxw_req = 0;
            if (uaw_req && a[1]) uaw_req = 0;
            if (c2h_req && a[2]) c2h_req = 0;
            if (rn && !pxw_req && q0.size() > 0 && (!gaps || $urandom_range(0, 2) != 0)) begin
                t = q0.pop_front(); pxw_req = 1; pxw_addr = t.a; pxw_data = t.d;
            end
            if (rn && !uaw_req && q1.size() > 0 && (!gaps || $urandom_range(0, 2) != 0)) begin
                t = q1.pop_front(); uaw_req = 1; uaw_addr = t.a; uaw_data = t.d;
            end
            if (rn && !c2h_req && q2.size() > 0 && (!gaps || $urandom_range(0, 2) != 0)) begin
                t = q2.pop_front(); c2h_req = 1; c2h_addr = t.a;
            end
        end
    end

    task automatic drain(input int budget);
        int n;
        n = 0;
        while ((q0.size() + q1.size() + q2.size()) != 0 || pxw_req || uaw_req || c2h_req
               || ret_q.size() != 0) begin
            @(negedge clk);
            n++;
            if (n > budget) begin
                n_vec++; n_bad++;
                $display("FAIL drain_timeout: got busy after %0d cycles expected idle", n);
                break;
            end
        end
        repeat (3) @(negedge clk);
    endtask

    initial begin
        int n;
        repeat (3) @(negedge clk);
        #1 rst_n = 1;
        repeat (10) @(negedge clk);

        // Single PXIe write
        q0.push_back({16'h0010, 32'hDEADBEEF});
        drain(50);

        // All three at once from the post-reset pointer
        q0.push_back({16'h0011, 32'h11111111});
        q1.push_back({16'h0012, 32'h22222222});
        q2.push_back({16'h0030, 32'h0});
        drain(50);

        // Write then read back the same address
        q0.push_back({16'h0020, 32'h12345678});
        drain(50);
        q2.push_back({16'h0020, 32'h0});
        n = 0;
        do begin @(negedge clk); n++; end while (!c2h_rvld && n < 20);
        chk("readback_rvld", c2h_rvld, 1'b1);
        chk("readback_data", c2h_rdata, 32'h12345678);
        drain(50);

        // Continuous c2h reads interleaved with continuous pxw writes
        for (int i = 0; i < 8; i++) begin
            q2.push_back({16'h0040 + 16'(i), 32'h0});
            q0.push_back({16'h0100 + 16'(i), $urandom});
        end
        drain(200);

        // Reset one cycle after a c2h port cycle
        q2.push_back({16'h0041, 32'h0});
        n = 0;
        do begin @(negedge clk); n++; end while (!c2h_ack && n < 20);
        chk("reset_test_ack", c2h_ack, 1'b1);
        @(negedge clk);
        #1 rst_n = 0;
        @(negedge clk);
        #1 rst_n = 1;
        repeat (5) @(negedge clk);

        // Randomised traffic on a small address range
        gaps = 1'b1;
        for (int i = 0; i < 150; i++) begin
            q0.push_back({16'($urandom_range(0, 15)), $urandom});
            q1.push_back({16'($urandom_range(0, 15)), $urandom});
            q2.push_back({16'($urandom_range(0, 15)), 32'h0});
        end
        drain(5000);
        chk("uaw_cnt_saturated", d2_uaw_cnt, 4'hF);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
